cart_bus_sequencer: RTL and testbench
=====================================

Name: cart_bus_sequencer

Overview:
- Sequences the physical cartridge bus (address, data, transceiver direction, rd/wr/CS strobes) for the GB-camera mapper path.
- Arbitrates between two requesters:
  - CPU/mapper side: mbc_addr and cart_di accesses.
  - Host side: save-RAM backup/restore over the bridge.
- Each granted request becomes one timed bus cycle (setup, strobe, hold).
- Sits between the mapper datapath and the cart_tran_bank* pin drivers.

Parameters:
- SETUP_CYC, 2: cycles the address/data are driven before the strobe; range 1..15.
- STROBE_CYC, 4: cycles rd_n/wr_n are held low; range 1..15.
- HOLD_CYC, 1: cycles the address/data are held after the strobe releases; range 1..15.
- STARVE_MAX, 4: consecutive CPU grants allowed while host waits before host is forced.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request; level, held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid when cpu_ack is high
- host_req  in  1  host request; level, held until host_ack
- host_we  in  1  1 = write
- host_addr  in  16  host address
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  8  read data, valid when host_ack is high
- bus_addr  out  16  cart address pins
- bus_dout  out  8  cart data out
- bus_din  in  8  cart data in (already synchronised)
- bus_dir  out  1  1 = drive the data pins toward the cart
- bus_rd_n  out  1  read strobe
- bus_wr_n  out  1  write strobe
- bus_cs_n  out  1  RAM chip select
- busy  out  1  high when not IDLE
- grant_host  out  1  high while the current cycle belongs to the host

Behaviour:
- Reset: clk_sys and reset_n as stated; reset is asynchronous and active-low. While reset_n is low:
  - FSM goes to IDLE.
  - bus_rd_n, bus_wr_n and bus_cs_n are 1.
  - bus_dir, busy, grant_host, cpu_ack and host_ack are 0.
  - bus_addr, bus_dout, cpu_rdata and host_rdata are 0.
  - Starvation count is 0.
- Reset mid-cycle: strobes release immediately (asynchronously). No ack is issued.
- FSM states: IDLE, SETUP, STROBE, HOLD. A single down-counter is loaded on every state entry.
- IDLE:
  - No request: stay in IDLE; bus_dir is 0; all strobes are high; bus_addr holds its last value.
  - Request present: arbitrate, latch addr/we/wdata/requester-id, move to SETUP.
- Arbitration:
  - CPU has priority.
  - If host_req has been pending across STARVE_MAX consecutive CPU grants, the next grant goes to the host.
  - The starvation count clears on any host grant, and while host_req is low.
- SETUP (SETUP_CYC cycles):
  - bus_addr is driven.
  - bus_cs_n = ~(addr[15:13]==3'b101), i.e. low for A000–BFFF; this applies from SETUP through HOLD.
  - Writes: bus_dir = 1 and bus_dout = wdata.
  - Then go to STROBE.
- STROBE (STROBE_CYC cycles):
  - Read: bus_rd_n = 0. Write: bus_wr_n = 0.
  - Reads sample bus_din on the last STROBE cycle into the granted requester's rdata register.
  - Then go to HOLD.
- HOLD (HOLD_CYC cycles):
  - Strobes are high; addr, CS, dir and dout are unchanged.
  - On the final HOLD cycle the granted requester's ack is high for exactly 1 cycle.
  - Then go to IDLE.
- Latency: grant edge to ack = SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; 7 with defaults.
- Throughput: at most one bus cycle per (latency+1) clocks, because IDLE always takes one cycle.
- Request withdrawn before ack: protocol violation. The cycle still completes and the ack still pulses.
- Both requesters raise requests in the same cycle: CPU wins unless the starvation rule forces the host.
- rdata registers hold their value until the next read completes for the same requester.
- Writes never touch rdata.
- The read strobe and the write strobe are never low together.
- bus_dir is never 1 during a read.

Decomposition:
- Package cart_bus_pkg holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD)
  - the requester id (REQ_CPU, REQ_HOST)
  - the RAM CS decode constant (3'b101)
  - a 4-bit counter width constant
- Sub-module cart_bus_arbiter holds the fixed-priority arbiter plus the starvation counter. Its outputs are grant and grant_id; it is evaluated only in IDLE.

Test Plan:
- CPU read at 0xA123 with bus_din = 0x5A:
  - rd_n is low for 4 cycles, starting 2 cycles after the grant.
  - cs_n is 0.
  - cpu_ack pulses 7 cycles after the grant, with cpu_rdata = 0x5A.
- Host write 0x3C to 0x4000:
  - dir = 1 and dout = 0x3C from SETUP through HOLD.
  - wr_n is low for 4 cycles.
  - cs_n = 1.
  - host_ack pulses once; grant_host = 1 throughout the cycle.
- cpu_req and host_req held continuously: grant order is CPU ×4, host, CPU ×4, host; no ack ever lands on the wrong requester.
- Simultaneous requests in one IDLE cycle with the starvation count at 0: CPU is served first and the host is served next.
- reset_n asserted in the middle of STROBE:
  - rd_n/wr_n/cs_n go to 1 and dir goes to 0 without waiting for a clock edge.
  - No ack is issued.
  - After release the FSM is in IDLE and busy = 0.
- Back-to-back CPU reads (0xA000→0x11, 0xA001→0x22): each ack carries the correct byte, and the two acks are 8 cycles apart.

Source files
------------

// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge bus sequencer.
// The CS decode marks the external RAM window (A000-BFFF).
package cart_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  localparam logic [2:0] RAM_CS_DECODE = 3'b101;
  localparam int         CNT_W         = 4;

  function automatic logic is_ram_addr(input logic [15:0] addr);
    return addr[15:13] == RAM_CS_DECODE;
  endfunction

endpackage

// File: rtl/cart_bus_arbiter.sv
// Fixed-priority CPU-first arbiter with a starvation counter that
// forces a host grant after STARVE_MAX back-to-back CPU wins.
module cart_bus_arbiter
  import cart_bus_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk_sys,
  input  logic    reset_n,
  input  logic    evaluate,
  input  logic    cpu_req,
  input  logic    host_req,
  output logic    grant,
  output req_id_t grant_id
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_cnt;
  logic                force_host;

  always_comb begin
    force_host = host_req && (starve_cnt >= STARVE_W'(STARVE_MAX));
    grant      = evaluate && (cpu_req || host_req);
    grant_id   = (force_host || !cpu_req) ? REQ_HOST : REQ_CPU;
  end

  // Counts CPU wins only while the host is actually waiting.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!host_req) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (grant_id == REQ_HOST)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/cart_bus_sequencer.sv
// Cartridge bus sequencer: turns one granted CPU or host request into a
// timed setup/strobe/hold cycle on the cart pins, then acks the requester.
module cart_bus_sequencer
  import cart_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_dir,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic        bus_cs_n,
  output logic        busy,
  output logic        grant_host
);

  bus_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             cur_we;
  req_id_t          cur_id;

  logic             grant;
  req_id_t          grant_id;
  logic [15:0]      sel_addr;
  logic             sel_we;
  logic [7:0]       sel_wdata;

  cart_bus_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arbiter (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .evaluate (state == IDLE),
    .cpu_req  (cpu_req),
    .host_req (host_req),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    sel_addr  = (grant_id == REQ_HOST) ? host_addr  : cpu_addr;
    sel_we    = (grant_id == REQ_HOST) ? host_we    : cpu_we;
    sel_wdata = (grant_id == REQ_HOST) ? host_wdata : cpu_wdata;
  end

  assign busy       = (state != IDLE);
  assign grant_host = busy && (cur_id == REQ_HOST);

  // Every pin is a register, so reset releases the strobes without a clock.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_we     <= 1'b0;
      cur_id     <= REQ_CPU;
      bus_addr   <= '0;
      bus_dout   <= '0;
      bus_dir    <= 1'b0;
      bus_rd_n   <= 1'b1;
      bus_wr_n   <= 1'b1;
      bus_cs_n   <= 1'b1;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= SETUP;
            cnt      <= CNT_W'(SETUP_CYC - 1);
            cur_id   <= grant_id;
            cur_we   <= sel_we;
            bus_addr <= sel_addr;
            bus_dir  <= sel_we;
            bus_cs_n <= ~is_ram_addr(sel_addr);
            if (sel_we)
              bus_dout <= sel_wdata;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= CNT_W'(STROBE_CYC - 1);
            if (cur_we)
              bus_wr_n <= 1'b0;
            else
              bus_rd_n <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state    <= HOLD;
            cnt      <= CNT_W'(HOLD_CYC - 1);
            bus_rd_n <= 1'b1;
            bus_wr_n <= 1'b1;
            if (!cur_we && cur_id == REQ_HOST)
              host_rdata <= bus_din;
            if (!cur_we && cur_id == REQ_CPU)
              cpu_rdata <= bus_din;
            if (HOLD_CYC == 1) begin
              cpu_ack  <= (cur_id == REQ_CPU);
              host_ack <= (cur_id == REQ_HOST);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state    <= IDLE;
            bus_dir  <= 1'b0;
            bus_cs_n <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              cpu_ack  <= (cur_id == REQ_CPU);
              host_ack <= (cur_id == REQ_HOST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_bus_sequencer.sv
// Self-checking bench for cart_bus_sequencer: vector table of single
// transactions plus directed arbitration, reset and back-to-back sequences.
module tb_cart_bus_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = '0;
  logic        bus_dir, bus_rd_n, bus_wr_n, bus_cs_n, busy, grant_host;

  int          compare_cnt = 0;
  int          mismatch_cnt = 0;
  int          cyc = 0;
  logic [7:0]  exp_cpu_rdata = '0;
  logic [7:0]  exp_host_rdata = '0;

  typedef struct {
    logic        host;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic        exp_cs_n;
  } vec_t;

  vec_t vecs [6];

  cart_bus_sequencer #(
    .SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(1), .STARVE_MAX(4)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .bus_addr   (bus_addr),
    .bus_dout   (bus_dout),
    .bus_din    (bus_din),
    .bus_dir    (bus_dir),
    .bus_rd_n   (bus_rd_n),
    .bus_wr_n   (bus_wr_n),
    .bus_cs_n   (bus_cs_n),
    .busy       (busy),
    .grant_host (grant_host)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compare_cnt++;
    if (actual !== expected) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One transaction from an idle bus; samples every cycle on the falling edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic active, strobe;
    @(negedge clk_sys);
    bus_din = v.din;
    if (v.host) begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_sys);
      active = (k <= 7);
      strobe = (k >= 3 && k <= 6);
      checkOutput($sformatf("v%0d busy c%0d", idx, k), 16'(busy), 16'(active));
      checkOutput($sformatf("v%0d rd_n c%0d", idx, k), 16'(bus_rd_n), 16'(!(strobe && !v.we)));
      checkOutput($sformatf("v%0d wr_n c%0d", idx, k), 16'(bus_wr_n), 16'(!(strobe && v.we)));
      checkOutput($sformatf("v%0d cs_n c%0d", idx, k), 16'(bus_cs_n), 16'(active ? v.exp_cs_n : 1'b1));
      checkOutput($sformatf("v%0d dir c%0d", idx, k), 16'(bus_dir), 16'(active && v.we));
      checkOutput($sformatf("v%0d grant_host c%0d", idx, k), 16'(grant_host), 16'(active && v.host));
      checkOutput($sformatf("v%0d cpu_ack c%0d", idx, k), 16'(cpu_ack), 16'(k == 7 && !v.host));
      checkOutput($sformatf("v%0d host_ack c%0d", idx, k), 16'(host_ack), 16'(k == 7 && v.host));
      if (active)
        checkOutput($sformatf("v%0d addr c%0d", idx, k), bus_addr, v.addr);
      if (active && v.we)
        checkOutput($sformatf("v%0d dout c%0d", idx, k), 16'(bus_dout), 16'(v.wdata));
      if (k == 7) begin
        if (!v.we && v.host) exp_host_rdata = v.din;
        if (!v.we && !v.host) exp_cpu_rdata = v.din;
        checkOutput($sformatf("v%0d cpu_rdata", idx), 16'(cpu_rdata), 16'(exp_cpu_rdata));
        checkOutput($sformatf("v%0d host_rdata", idx), 16'(host_rdata), 16'(exp_host_rdata));
        cpu_req = 1'b0;
        host_req = 1'b0;
      end
    end
  endtask

  initial begin
    int n, t1;
    logic [9:0] starve_order;

    vecs[0] = '{host: 1'b0, we: 1'b0, addr: 16'hA123, wdata: 8'h00, din: 8'h5A, exp_cs_n: 1'b0};
    vecs[1] = '{host: 1'b1, we: 1'b1, addr: 16'h4000, wdata: 8'h3C, din: 8'hEE, exp_cs_n: 1'b1};
    vecs[2] = '{host: 1'b1, we: 1'b0, addr: 16'hB7FF, wdata: 8'h00, din: 8'hC3, exp_cs_n: 1'b0};
    vecs[3] = '{host: 1'b0, we: 1'b1, addr: 16'hA055, wdata: 8'h99, din: 8'h12, exp_cs_n: 1'b0};
    vecs[4] = '{host: 1'b0, we: 1'b0, addr: 16'h0150, wdata: 8'h00, din: 8'h0F, exp_cs_n: 1'b1};
    vecs[5] = '{host: 1'b1, we: 1'b1, addr: 16'hBFFF, wdata: 8'h01, din: 8'h34, exp_cs_n: 1'b0};

    #12;
    checkOutput("reset rd_n", 16'(bus_rd_n), 16'h1);
    checkOutput("reset wr_n", 16'(bus_wr_n), 16'h1);
    checkOutput("reset cs_n", 16'(bus_cs_n), 16'h1);
    checkOutput("reset dir", 16'(bus_dir), 16'h0);
    checkOutput("reset busy", 16'(busy), 16'h0);
    checkOutput("reset grant_host", 16'(grant_host), 16'h0);
    checkOutput("reset acks", 16'({cpu_ack, host_ack}), 16'h0);
    checkOutput("reset addr", bus_addr, 16'h0000);
    checkOutput("reset dout", 16'(bus_dout), 16'h0);
    checkOutput("reset rdata", {cpu_rdata, host_rdata}, 16'h0000);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i], i);

    // Both requesters held: CPU x4, host, CPU x4, host.
    @(negedge clk_sys);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hA000;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'hA100;
    bus_din = 8'h44;
    starve_order = 10'b10_0001_0000;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk_sys);
      if (cpu_ack || host_ack) begin
        checkOutput($sformatf("starve ack%0d is host", n), 16'(host_ack), 16'(starve_order[n]));
        checkOutput($sformatf("starve ack%0d single", n), 16'(cpu_ack && host_ack), 16'h0);
        checkOutput($sformatf("starve ack%0d owner", n), 16'(grant_host), 16'(host_ack));
        checkOutput($sformatf("starve ack%0d rdata", n),
                    16'(host_ack ? host_rdata : cpu_rdata), 16'h0044);
        n++;
      end
    end
    checkOutput("starve ack count", 16'(n), 16'd10);
    cpu_req = 1'b0; host_req = 1'b0;
    exp_cpu_rdata = 8'h44; exp_host_rdata = 8'h44;
    repeat (2) @(negedge clk_sys);

    // Simultaneous requests with a cleared starvation count.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hA010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'hA020;
    bus_din = 8'h77;
    n = 0;
    for (int c = 0; c < 60 && n < 2; c++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin
        checkOutput("simul cpu first", 16'(n), 16'd0);
        checkOutput("simul cpu rdata", 16'(cpu_rdata), 16'h0077);
        cpu_req = 1'b0;
        n++;
      end else if (host_ack) begin
        checkOutput("simul host second", 16'(n), 16'd1);
        checkOutput("simul host rdata", 16'(host_rdata), 16'h0077);
        host_req = 1'b0;
        n++;
      end
    end
    checkOutput("simul ack count", 16'(n), 16'd2);
    cpu_req = 1'b0; host_req = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Reset asserted between clock edges during the write strobe.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hA000; cpu_wdata = 8'hAA;
    repeat (4) @(negedge clk_sys);
    checkOutput("rst pre wr_n", 16'(bus_wr_n), 16'h0);
    checkOutput("rst pre dir", 16'(bus_dir), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst async wr_n", 16'(bus_wr_n), 16'h1);
    checkOutput("rst async rd_n", 16'(bus_rd_n), 16'h1);
    checkOutput("rst async cs_n", 16'(bus_cs_n), 16'h1);
    checkOutput("rst async dir", 16'(bus_dir), 16'h0);
    cpu_req = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    exp_cpu_rdata = '0; exp_host_rdata = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_sys);
      checkOutput($sformatf("rst after ack c%0d", c), 16'(cpu_ack || host_ack), 16'h0);
      checkOutput($sformatf("rst after busy c%0d", c), 16'(busy), 16'h0);
    end
    checkOutput("rst cpu_rdata", 16'(cpu_rdata), 16'(exp_cpu_rdata));

    // Back-to-back CPU reads, acks 8 cycles apart.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hA000; bus_din = 8'h11;
    n = 0; t1 = 0;
    for (int c = 0; c < 60 && n < 2; c++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin
        if (n == 0) begin
          checkOutput("b2b first rdata", 16'(cpu_rdata), 16'h0011);
          t1 = cyc;
          cpu_addr = 16'hA001; bus_din = 8'h22;
        end else begin
          checkOutput("b2b second rdata", 16'(cpu_rdata), 16'h0022);
          checkOutput("b2b ack spacing", 16'(cyc - t1), 16'd8);
          cpu_req = 1'b0;
        end
        n++;
      end
    end
    checkOutput("b2b ack count", 16'(n), 16'd2);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
